ifilter_fir_seq: RTL

Sequential, parametrised LPC inverse (analysis) filter: computes residue e[n] = x[n] + sum_{k=1..ORDER} a_k·x[n−k] one tap per clock on a single shared multiply-accumulate datapath. It holds its own sample history and coefficient bank and uses valid/ready handshakes on both sides. It generalises the single-tap ifilter MAC stage to a complete ORDER-tap filter, sitting between the frame sample source and the residue encoder.

---
 rtl/ifilter_pkg.sv | 25 ++
 rtl/ifilter_mac_round.sv | 29 ++
 rtl/ifilter_fir_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ifilter_pkg.sv
// Shared types and fixed-point constants for the LPC inverse-filter datapath.
// Widths of the saturation limits follow the residue width chosen by the instantiating block.
package ifilter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam int X_FRAC     = 15;
    localparam int A_FRAC     = 28;
    localparam int ACC_FRAC   = 30;
    // Q.43 product back to the Q.30 accumulator grid
    localparam int PROD_SHIFT = X_FRAC + A_FRAC - ACC_FRAC;

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/ifilter_mac_round.sv
// One filter tap: signed sample x coefficient product, round-half-up to the
// accumulator grid and add to the running sum. Purely combinational.
module ifilter_mac_round
    import ifilter_pkg::*;
#(
    parameter int XW   = 16,
    parameter int AW   = 32,
    parameter int ACCW = 48
) (
    input  logic [XW-1:0]   hist_x,
    input  logic [AW-1:0]   coef,
    input  logic [ACCW-1:0] acc_in,
    output logic [ACCW-1:0] acc_out
);

    localparam int PW = XW + AW;
    localparam logic signed [PW:0] PROD_HALF = (PW + 1)'(1'b1) << (PROD_SHIFT - 1);

    logic signed [PW-1:0] prod_s;
    logic signed [PW:0]   prod_rnd_s;
    logic signed [ACCW-1:0] term_s;

    assign prod_s     = PW'($signed(hist_x)) * PW'($signed(coef));
    // one guard bit so the rounding constant can never wrap the product
    assign prod_rnd_s = {prod_s[PW-1], prod_s} + PROD_HALF;
    assign term_s     = ACCW'(prod_rnd_s >>> PROD_SHIFT);
    assign acc_out    = acc_in + term_s;

endmodule

// File: rtl/ifilter_fir_seq.sv
// Sequential LPC analysis filter: e[n] = x[n] + sum a_k*x[n-k], one tap per clock
// on a shared MAC, with local coefficient bank, sample history and valid/ready ports.
module ifilter_fir_seq
    import ifilter_pkg::*;
#(
    parameter int ORDER = 10,
    parameter int XW    = 16,
    parameter int AW    = 32,
    parameter int ACCW  = 48
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       coef_we,
    input  logic [$clog2(ORDER+1)-1:0] coef_addr,
    input  logic [AW-1:0]              coef_data,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_first,
    input  logic [XW-1:0]              x_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XW-1:0]              residue,
    output logic                       out_sat
);

    localparam int KW  = $clog2(ORDER + 1);
    localparam int IW  = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam int OSH = ACC_FRAC - X_FRAC;
    localparam logic signed [ACCW:0] OUT_HALF = (ACCW + 1)'(1'b1) << (OSH - 1);
    localparam logic signed [ACCW:0] RES_MAX  = (ACCW + 1)'(sat_max(XW));
    localparam logic signed [ACCW:0] RES_MIN  = (ACCW + 1)'(sat_min(XW));

    state_e                 state_r;
    state_e                 state_next_s;
    logic [KW-1:0]          k_r;
    logic [AW-1:0]          coef_r [ORDER];
    logic [XW-1:0]          hist_r [ORDER];
    logic [XW-1:0]          x_cur_r;
    logic [ACCW-1:0]        acc_r;
    logic [ACCW-1:0]        acc_next_s;
    logic [IW-1:0]          tap_idx_s;
    logic [XW-1:0]          tap_hist_s;
    logic [AW-1:0]          tap_coef_s;
    logic                   accept_s;
    logic                   last_tap_s;
    logic                   coef_hit_s;
    logic signed [ACCW:0]   rnd_sum_s;
    logic signed [ACCW:0]   rnd_shift_s;
    logic [XW-1:0]          res_s;
    logic                   sat_s;
    logic [XW-1:0]          residue_r;
    logic                   out_sat_r;

    assign accept_s   = in_valid && (state_r == IDLE);
    assign last_tap_s = (k_r == KW'(ORDER));
    assign coef_hit_s = coef_we && (state_r == IDLE) &&
                        (coef_addr != {KW{1'b0}}) && (coef_addr <= KW'(ORDER));
    // tap k reads coefficient a_k and sample x[n-k], both stored at index k-1
    assign tap_idx_s  = IW'(k_r - KW'(1));
    assign tap_hist_s = hist_r[tap_idx_s];
    assign tap_coef_s = coef_r[tap_idx_s];

    ifilter_mac_round #(
        .XW   (XW),
        .AW   (AW),
        .ACCW (ACCW)
    ) u_mac (
        .hist_x  (tap_hist_s),
        .coef    (tap_coef_s),
        .acc_in  (acc_r),
        .acc_out (acc_next_s)
    );

    assign rnd_sum_s   = {acc_next_s[ACCW-1], acc_next_s} + OUT_HALF;
    assign rnd_shift_s = rnd_sum_s >>> OSH;

    // Final Q.30 -> Q1.15 conversion with clipping, taken from the last tap's sum
    always_comb begin
        res_s = rnd_shift_s[XW-1:0];
        sat_s = 1'b0;
        if (rnd_shift_s > RES_MAX) begin
            res_s = RES_MAX[XW-1:0];
            sat_s = 1'b1;
        end else if (rnd_shift_s < RES_MIN) begin
            res_s = RES_MIN[XW-1:0];
            sat_s = 1'b1;
        end else begin
            res_s = rnd_shift_s[XW-1:0];
            sat_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = MAC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MAC: begin
                if (last_tap_s) begin
                    state_next_s = OUT;
                end else begin
                    state_next_s = MAC;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = OUT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Coefficient bank, writable only while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ORDER; i++) begin
                coef_r[i] <= {AW{1'b0}};
            end
        end else if (coef_hit_s) begin
            coef_r[IW'(coef_addr - KW'(1))] <= coef_data;
        end
    end

    // Accumulator, tap counter, history and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r     <= {ACCW{1'b0}};
            k_r       <= {KW{1'b0}};
            x_cur_r   <= {XW{1'b0}};
            residue_r <= {XW{1'b0}};
            out_sat_r <= 1'b0;
            for (int i = 0; i < ORDER; i++) begin
                hist_r[i] <= {XW{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        acc_r   <= ACCW'($signed(x_in)) <<< OSH;
                        k_r     <= KW'(1);
                        x_cur_r <= x_in;
                        if (in_first) begin
                            for (int i = 0; i < ORDER; i++) begin
                                hist_r[i] <= {XW{1'b0}};
                            end
                        end
                    end
                end
                MAC: begin
                    acc_r <= acc_next_s;
                    k_r   <= k_r + KW'(1);
                    if (last_tap_s) begin
                        for (int i = ORDER - 1; i > 0; i--) begin
                            hist_r[i] <= hist_r[i-1];
                        end
                        hist_r[0] <= x_cur_r;
                        residue_r <= res_s;
                        out_sat_r <= sat_s;
                    end
                end
                OUT: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = (state_r == OUT);
    assign residue   = residue_r;
    assign out_sat   = out_sat_r;

endmodule
